// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32I pipeline stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds default datapath widths, control-word bit positions and the
// state encoding used by the elastic pipeline buffers.
package rv32_pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int RD_W_DEF   = 5;
  localparam int CTRL_W_DEF = 4;

  // Bit positions inside the packed control word travelling EX -> MEM -> WB.
  localparam int CTRL_WBSEL = 0;
  localparam int CTRL_WE    = 1;
  localparam int CTRL_MEMRW = 2;
  localparam int CTRL_MEMV  = 3;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready on both sides and sync flush.
// Latency: 1 cycle from push to out_valid when empty; 1 transfer/cycle sustained.
// Backpressure: in_ready is registered (drops only in FULL), no comb path from out_ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous kill of all held entries (beats push/pop)
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data = HEAD entry
//   occupancy       entries held (0..2)
module pipe_skid_buf
  import rv32_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  skid_state_t  r_state;
  skid_state_t  w_next_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_in_ready;

  logic w_push;
  logic w_pop;
  logic w_head_from_in;
  logic w_head_from_skid;
  logic w_skid_from_in;
  logic w_out_valid;
  logic [1:0] w_occ;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = w_out_valid & out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_head_from_in   = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    w_out_valid      = 1'b0;
    w_occ            = 2'd0;
    case (r_state)
      EMPTY: begin
        w_occ = 2'd0;
        if (w_push) begin
          w_next_state   = ONE;
          w_head_from_in = 1'b1;
        end
      end
      ONE: begin
        w_occ       = 2'd1;
        w_out_valid = 1'b1;
        if (w_push && w_pop) begin
          // Pass-through: the popped HEAD is replaced by the incoming entry.
          w_head_from_in = 1'b1;
        end else if (w_push) begin
          w_next_state   = FULL;
          w_skid_from_in = 1'b1;
        end else if (w_pop) begin
          w_next_state = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        w_occ       = 2'd2;
        w_out_valid = 1'b1;
        if (w_pop) begin
          w_next_state     = ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: begin
        w_next_state = EMPTY;
      end
    endcase
    // Flush drops everything, including a push accepted in the same cycle.
    if (flush) begin
      w_next_state     = EMPTY;
      w_head_from_in   = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      // Registered ready: decided from next state, so it never depends
      // combinationally on out_ready.
      r_in_ready <= (w_next_state != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_head_from_in) begin
        r_head <= in_data;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_head;
  assign occupancy = w_occ;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM elastic pipeline stage: skid buffer, bubble squash and forwarding tap.
// Latency: 1 cycle EX -> MEM when empty; 1 instruction/cycle with out_ready high.
// Backpressure: absorbs one extra entry; in_ready registered, low only when full.
//
// Ports:
//   clk, rst, flush       clock, async active-high reset, sync flush
//   in_*                  EX-side handshake and payload (alu_out, rs2, rd, ctrl)
//   out_*                 MEM-side handshake and HEAD payload; out_ctrl is 0 on bubbles
//   fwd_valid/rd/data     forwarding tap for the hazard unit
//   occupancy             entries held (0..2)
module exmem_skid_stage
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RD_W     = RD_W_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int WE_BIT   = CTRL_WE,
  parameter int MEMV_BIT = CTRL_MEMV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_out,
  output logic [XLEN-1:0]   out_rs2,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [1:0]        occupancy
);

  localparam int W = CTRL_W + RD_W + 2 * XLEN;

  // Both controls that have side effects downstream must be real bits of
  // the control word and distinct, otherwise the squash/forward logic lies.
  if (WE_BIT >= CTRL_W || MEMV_BIT >= CTRL_W || WE_BIT == MEMV_BIT) begin : g_bad_ctrl_idx
    $error("exmem_skid_stage: WE_BIT/MEMV_BIT out of range or overlapping");
  end

  logic [W-1:0]      w_in_pack;
  logic [W-1:0]      w_head;
  logic              w_valid;
  logic [XLEN-1:0]   w_head_alu;
  logic [XLEN-1:0]   w_head_rs2;
  logic [RD_W-1:0]   w_head_rd;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [CTRL_W-1:0] w_ctrl_sq;

  assign w_in_pack = {in_ctrl, in_rd, in_rs2, in_alu_out};

  pipe_skid_buf #(
    .W (W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pack),
    .out_valid (w_valid),
    .out_ready (out_ready),
    .out_data  (w_head),
    .occupancy (occupancy)
  );

  assign {w_head_ctrl, w_head_rd, w_head_rs2, w_head_alu} = w_head;

  // Bubble squash: HEAD may hold stale data after a flush, so the controls
  // are gated by valid and reg_we/mem_val can never fire on a bubble.
  assign w_ctrl_sq = w_valid ? w_head_ctrl : '0;

  assign out_valid   = w_valid;
  assign out_alu_out = w_head_alu;
  assign out_rs2     = w_head_rs2;
  assign out_rd      = w_head_rd;
  assign out_ctrl    = w_ctrl_sq;

  // x0 writes are architectural no-ops and must never be forwarded.
  assign fwd_valid = w_valid & w_ctrl_sq[WE_BIT] & (w_head_rd != '0);
  assign fwd_rd    = w_head_rd;
  assign fwd_data  = w_head_alu;

endmodule
